// File: rtl/vga_bounce_sprite.sv
// vga_bounce_sprite: pixel stage between the VGA timing generator and the
// PMOD output mapping. It moves a sprite once per frame, bouncing it off the
// active-area edges, and draws it over a checkerboard background. RGB and the
// sync signals leave together, one clk after hpos/vpos/display_on.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   pause, speed[2:0]     freeze motion / pixels moved per frame per axis
//   hsync_in, vsync_in    sync from the timing generator
//   display_on            active-video flag
//   hpos[9:0], vpos[9:0]  current pixel coordinates
//   hsync_out, vsync_out  sync delayed by 1 clk
//   r, g, b [1:0]         registered colour
//   frame_tick            one-clk pulse per frame (on the vsync leading edge)
//   bounce_count[7:0]     total bounce events, wrapping
//
// Optional feature: define VGA_SPRITE_COLOR_CYCLE_EN to step the sprite colour
// on every bounce. Without it the sprite is fixed white.
module vga_bounce_sprite #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned BOX_W           = 32,
  parameter int unsigned BOX_H           = 32,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic [2:0] speed,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);

  localparam int unsigned PW = 10;
  localparam int unsigned SW = 11;
  localparam logic [SW-1:0] XMAX    = SW'(H_ACTIVE - BOX_W);
  localparam logic [SW-1:0] YMAX    = SW'(V_ACTIVE - BOX_H);
  localparam logic [SW-1:0] BOX_W_S = SW'(BOX_W);
  localparam logic [SW-1:0] BOX_H_S = SW'(BOX_H);
  localparam logic          SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic          vsync_d;
  logic [PW-1:0] box_x, box_y;
  logic          dir_x, dir_y;        // 1 = moving toward larger coordinates
  logic [PW-1:0] nx, ny;
  logic          ndx, ndy;
  logic          bounce_x, bounce_y;
  logic [SW-1:0] step, x_sum, y_sum;
  logic          do_move;
  logic          in_box;
  logic [1:0]    spr_r, spr_g, spr_b;
  logic [1:0]    pix_r, pix_g, pix_b;

  // Next position/direction for both axes, saturating at the edges
  always_comb begin
    step     = SW'(speed);
    x_sum    = SW'(box_x) + step;
    y_sum    = SW'(box_y) + step;
    nx       = box_x;
    ny       = box_y;
    ndx      = dir_x;
    ndy      = dir_y;
    bounce_x = 1'b0;
    bounce_y = 1'b0;
    if (dir_x) begin
      if (x_sum >= XMAX) begin
        nx = PW'(XMAX); ndx = 1'b0; bounce_x = 1'b1;
      end else begin
        nx = PW'(x_sum);
      end
    end else begin
      if (SW'(box_x) <= step) begin
        nx = '0; ndx = 1'b1; bounce_x = 1'b1;
      end else begin
        nx = PW'(SW'(box_x) - step);
      end
    end
    if (dir_y) begin
      if (y_sum >= YMAX) begin
        ny = PW'(YMAX); ndy = 1'b0; bounce_y = 1'b1;
      end else begin
        ny = PW'(y_sum);
      end
    end else begin
      if (SW'(box_y) <= step) begin
        ny = '0; ndy = 1'b1; bounce_y = 1'b1;
      end else begin
        ny = PW'(SW'(box_y) - step);
      end
    end
  end

  // Motion is applied on the edge that closes the frame_tick cycle
  assign do_move = frame_tick && !pause && (speed != 3'd0);

`ifdef VGA_SPRITE_COLOR_CYCLE_EN
  logic [2:0] color_idx;

  // Colour index walks 1..7, never 0, one step per bounce event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_idx <= 3'd7;
    end else if (do_move && (bounce_x || bounce_y)) begin
      color_idx <= (color_idx == 3'd7) ? 3'd1 : color_idx + 3'd1;
    end
  end

  assign spr_r = {2{color_idx[0]}};
  assign spr_g = {2{color_idx[1]}};
  assign spr_b = {2{color_idx[2]}};
`else
  assign spr_r = 2'b11;
  assign spr_g = 2'b11;
  assign spr_b = 2'b11;
`endif

  // Pixel colour: blank, sprite, or checkerboard background
  always_comb begin
    in_box = (SW'(hpos) >= SW'(box_x)) && (SW'(hpos) < SW'(box_x) + BOX_W_S) &&
             (SW'(vpos) >= SW'(box_y)) && (SW'(vpos) < SW'(box_y) + BOX_H_S);
    pix_r = 2'b00;
    pix_g = 2'b00;
    pix_b = 2'b00;
    if (display_on) begin
      if (in_box) begin
        pix_r = spr_r; pix_g = spr_g; pix_b = spr_b;
      end else if (hpos[5] ^ vpos[5]) begin
        pix_r = 2'b01; pix_g = 2'b01; pix_b = 2'b01;
      end
    end
  end

  // vsync_d resets to the active level so a vsync held active through reset
  // release cannot fake a frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_out    <= SYNC_IDLE;
      vsync_out    <= SYNC_IDLE;
      vsync_d      <= ~SYNC_IDLE;
      frame_tick   <= 1'b0;
      r            <= 2'b00;
      g            <= 2'b00;
      b            <= 2'b00;
      box_x        <= '0;
      box_y        <= '0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      bounce_count <= 8'd0;
    end else begin
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      vsync_d    <= vsync_in;
      frame_tick <= ((vsync_in ^ SYNC_IDLE) == 1'b1) && ((vsync_d ^ SYNC_IDLE) == 1'b0);
      r          <= pix_r;
      g          <= pix_g;
      b          <= pix_b;
      if (do_move) begin
        box_x <= nx;
        box_y <= ny;
        dir_x <= ndx;
        dir_y <= ndy;
        if (bounce_x || bounce_y) begin
          bounce_count <= bounce_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_bounce_sprite.sv
// Directed bench for vga_bounce_sprite: reset, motion, pause/speed sampling,
// right-edge bounce, colour stepping and a simultaneous corner bounce on a
// second instance with a 480x480 active area.
module tb_vga_bounce_sprite;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause;
  logic [2:0] speed;
  logic       hsync_in, vsync_in, display_on;
  logic [9:0] hpos, vpos;

  logic       hsync_out, vsync_out, frame_tick;
  logic [1:0] r, g, b;
  logic [7:0] bounce_count;

  logic       hsync_out2, vsync_out2, frame_tick2;
  logic [1:0] r2, g2, b2;
  logic [7:0] bounce_count2;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_count = 0;
  int tick_run   = 0;
  int tick_wide  = 0;

  always #5 clk = ~clk;

  vga_bounce_sprite dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .speed(speed),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .r(r), .g(g), .b(b), .frame_tick(frame_tick), .bounce_count(bounce_count)
  );

  vga_bounce_sprite #(.H_ACTIVE(480), .V_ACTIVE(480), .BOX_W(32), .BOX_H(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .pause(pause), .speed(speed),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .hsync_out(hsync_out2), .vsync_out(vsync_out2),
    .r(r2), .g(g2), .b(b2), .frame_tick(frame_tick2), .bounce_count(bounce_count2)
  );

  // Count frame_tick pulses and flag any pulse longer than one clk
  always @(negedge clk) begin
    if (frame_tick) begin
      tick_count++;
      tick_run++;
      if (tick_run > 1) tick_wide++;
    end else begin
      tick_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected sprite colour {r,g,b} after a given number of bounces
  function automatic logic [5:0] spr_exp(input int bounces);
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
    logic [2:0] idx;
    idx = (bounces == 0) ? 3'd7 : 3'((bounces - 1) % 7 + 1);
    return {{2{idx[0]}}, {2{idx[1]}}, {2{idx[2]}}};
`else
    return 6'b111111 | 6'(bounces & 0);
`endif
  endfunction

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vsync_in = 1'b0;
      repeat (3) @(negedge clk);
      vsync_in = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic [5:0] rgb);
    @(negedge clk);
    hpos = x; vpos = y; display_on = 1'b1;
    @(posedge clk);
    #1 rgb = {r, g, b};
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] px;
  int t0, w0;

  initial begin
    rst_n = 1'b0; pause = 1'b0; speed = 3'd0;
    hsync_in = 1'b1; vsync_in = 1'b1; display_on = 1'b0;
    hpos = '0; vpos = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Freshly reset: sprite at origin over the checkerboard
    probe(10'd0, 10'd0, px);   check("pix_0_0", px, spr_exp(0));
    probe(10'd32, 10'd0, px);  check("pix_32_0", px, 6'b010101);

    // Mid-line reset with sync active and the sprite being drawn
    @(negedge clk);
    hpos = 10'd3; vpos = 10'd3; display_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_hsync", hsync_out, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", {r, g, b}, 6'b000000);
    check("rst_hsync", hsync_out, 1'b1);
    check("rst_vsync", vsync_out, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_bounce", bounce_count, 8'd0);
    t0 = tick_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;                       // vsync_in still active
    repeat (4) @(negedge clk);
    check("no_tick_after_rst", tick_count - t0, 0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (2) @(negedge clk);

    // Motion: 10 frames at speed 4
    speed = 3'd4;
    t0 = tick_count; w0 = tick_wide;
    frames(10);
    check("tick_count_10", tick_count - t0, 10);
    check("tick_width", tick_wide - w0, 0);
    probe(10'd40, 10'd40, px); check("pix_40_40", px, spr_exp(0));
    probe(10'd39, 10'd40, px); check("pix_39_40", px, 6'b000000);
    check("motion_x", dut.box_x, 10'd40);

    // Pause: position holds, ticks continue
    pause = 1'b1;
    t0 = tick_count;
    frames(5);
    check("pause_ticks", tick_count - t0, 5);
    check("pause_x", dut.box_x, 10'd40);
    check("pause_y", dut.box_y, 10'd40);
    probe(10'd40, 10'd40, px); check("pause_pix", px, spr_exp(0));

    // Speed 2 for one tick, then switch to 5 mid-frame after the update
    pause = 1'b0; speed = 3'd2;
    @(negedge clk) vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    speed = 3'd5;
    check("speed2_x", dut.box_x, 10'd42);
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    check("speed_hold_x", dut.box_x, 10'd42);
    frames(1);
    check("speed5_x", dut.box_x, 10'd47);
    check("speed5_y", dut.box_y, 10'd47);

    // Right edge at speed 7: y bounces at tick 64, x reaches 602 at tick 86
    do_reset();
    speed = 3'd7;
    frames(86);
    check("edge_x602", dut.box_x, 10'd602);
    check("edge_y294", dut.box_y, 10'd294);
    check("edge_cnt1", bounce_count, 8'd1);
    probe(10'd602, 10'd294, px); check("color_1st", px, spr_exp(1));
    frames(1);
    check("edge_x608", dut.box_x, 10'd608);
    check("edge_dirx", dut.dir_x, 1'b0);
    check("edge_cnt2", bounce_count, 8'd2);
    probe(10'd608, 10'd287, px); check("edge_pix_in", px, spr_exp(2));
    probe(10'd607, 10'd287, px); check("edge_pix_out", px, 6'b000000);
    frames(1);
    check("edge_x601", dut.box_x, 10'd601);

    // Bounces at ticks 128,174,192,256 then 7th at 261
    frames(172);
    check("t260_cnt6", bounce_count, 8'd6);
    check("t260_x", dut.box_x, 10'd602);
    check("t260_y", dut.box_y, 10'd28);
    probe(10'd602, 10'd28, px); check("color_6th", px, spr_exp(6));
    frames(1);
    check("t261_cnt7", bounce_count, 8'd7);
    probe(10'd608, 10'd35, px); check("color_7th", px, spr_exp(7));

    // Corner on a 480x480 area at speed 1
    do_reset();
    speed = 3'd1;
    frames(447);
    check("corner_pre_x", dut2.box_x, 10'd447);
    check("corner_pre_cnt", bounce_count2, 8'd0);
    frames(1);
    check("corner_x", dut2.box_x, 10'd448);
    check("corner_y", dut2.box_y, 10'd448);
    check("corner_dirs", {dut2.dir_x, dut2.dir_y}, 2'b00);
    check("corner_cnt", bounce_count2, 8'd1);
    frames(1);
    check("corner_after", {dut2.box_x, dut2.box_y}, {10'd447, 10'd447});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_bounce_sprite.md
# vga_bounce_sprite

Pixel-generation stage that sits directly downstream of the VGA timing generator (`hvsync_generator`) and upstream of the TinyVGA PMOD output mapping. Each frame it moves a rectangular sprite that bounces off the active-area edges, paints it over a checkerboard background, and registers RGB together with delayed sync so colour and sync leave aligned. Movement is clocked entirely from `clk`; a synchronous vsync edge detector replaces clocking logic from `vsync`.

## Interface

- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BOX_W, 32, sprite width in pixels; legal range 1 to H_ACTIVE-1
- BOX_H, 32, sprite height in lines; legal range 1 to V_ACTIVE-1
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync pulses are low

- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pause  in  1  1 freezes motion
- speed  in  3  pixels moved per frame on each axis, 0..7
- hsync_in  in  1  from timing generator
- vsync_in  in  1  from timing generator
- display_on  in  1  active-video flag
- hpos  in  10  current pixel x
- vpos  in  10  current pixel y
- hsync_out  out  1  hsync_in delayed 1 clk
- vsync_out  out  1  vsync_in delayed 1 clk
- r, g, b  out  2 each  registered colour
- frame_tick  out  1  one-clk pulse per frame
- bounce_count  out  8  total bounce events, wraps 255 to 0

## Operation

- Reset values:
  - r/g/b = 0.
  - hsync_out/vsync_out = inactive level (1 when SYNC_ACTIVE_LOW=1).
  - frame_tick = 0, bounce_count = 0.
  - box_x = box_y = 0, both directions positive.
- Frame detect: `vsync_d` holds the last sample of vsync_in. When vsync_in is active and `vsync_d` is inactive, frame_tick is set for exactly one cycle.
- Position update happens on the edge that ends the frame_tick cycle. It is skipped when pause=1 or speed=0. Skipped updates change no position, direction or count.
- Let step = speed sampled in the frame_tick cycle, and XMAX = H_ACTIVE-BOX_W.
- X axis, positive direction:
  - If box_x+step >= XMAX: box_x = XMAX, direction becomes negative, bounce.
  - Otherwise: box_x += step.
- X axis, negative direction:
  - If box_x <= step: box_x = 0, direction becomes positive, bounce.
  - Otherwise: box_x -= step.
- Y axis uses the same rules with box_y, V_ACTIVE and BOX_H.
- Sums are computed 11 bits wide; no wrap-around.
- Corner case: when X and Y bounce in the same update, both directions flip and bounce_count increments by exactly 1.
- Inside sprite: box_x <= hpos < box_x+BOX_W and box_y <= vpos < box_y+BOX_H.
- Pixel colour:
  - display_on=0: all channels 00.
  - Inside sprite: sprite colour.
  - Outside sprite: all channels 01 when hpos[5]^vpos[5] = 1, otherwise 00.
- Position changes only at the vsync edge, i.e. during vertical blanking. A displayed frame never tears.

## Timing

- RGB latency is 1 clk from hpos/vpos/display_on. Sync outputs get the same 1-clk delay, so they stay aligned.
- frame_tick rises 1 clk after the first active vsync_in sample.
- The new position is in effect 2 clks after that sample.
- speed and pause are sampled only in the frame_tick cycle. Mid-frame changes take effect at the next tick.
- rst_n assertion mid-frame immediately forces all reset values. After release, the first frame_tick needs a fresh inactive-to-active vsync transition.

## Configuration

- Macro: `VGA_SPRITE_COLOR_CYCLE_EN`.
- Defined:
  - A 3-bit colour index resets to 7.
  - Each bounce event advances the index: 7 goes to 1, otherwise index+1. The index is never 0.
  - Sprite colour is r={idx[0],idx[0]}, g={idx[1],idx[1]}, b={idx[2],idx[2]}.
- Undefined: the sprite is fixed white (11/11/11) and no index register exists. bounce_count behaves identically in both builds.

## Test plan

- Reset: hold rst_n low mid-line.
  - Required: r/g/b=0, hsync_out=vsync_out=1, frame_tick=0, bounce_count=0.
  - After release, pixel (0,0) is white and pixel (32,0) is background.
- Motion: speed=4, let 10 frames elapse.
  - Required: pixel (40,40) is sprite, pixel (39,40) is background, frame_tick pulsed exactly 10 times, each 1 clk wide.
- Right-edge bounce: default parameters, speed=7, box_x=602 positive.
  - Next tick: box_x=608, X direction negative, bounce_count+1.
  - Following tick: box_x=601.
- Corner: H_ACTIVE=V_ACTIVE=480, BOX 32×32, speed=1.
  - Tick 448: box=(448,448), both directions flip, bounce_count=1 (not 2).
- Pause and speed: pause=1 for 5 frames, then change speed 2→5 mid-frame.
  - Required: position unchanged while paused and frame_tick still pulses.
  - The speed change applies only from the next tick.
- Colour cycling: with `VGA_SPRITE_COLOR_CYCLE_EN` defined, the sprite is 11/11/11 after reset.
  - After the 1st bounce: r=11, g=00, b=00. After the 7th bounce: 11/11/11 again.
  - With the macro undefined, the sprite stays white throughout.
